// File: rtl/bsg_manycore_edge_inject_arb.sv
// Round-robin injector that shares one manycore edge link among several off-array requesters,
// with per-requester outstanding credits, a one-entry output register and a drain/quiesce mode.
module bsg_manycore_edge_inject_arb #(
   parameter int unsigned num_req_p      = 3,
   parameter int unsigned packet_width_p = 32,
   parameter int unsigned max_out_p      = 2,
   localparam int unsigned id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   localparam int unsigned cnt_width_lp  = (max_out_p + 1 > 1) ? $clog2(max_out_p + 1) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [num_req_p-1:0]                  req_v_i,
   input  logic [num_req_p*packet_width_p-1:0]   req_data_i,
   output logic [num_req_p-1:0]                  req_ready_o,
   output logic                                  link_v_o,
   output logic [packet_width_p-1:0]             link_data_o,
   input  logic                                  link_ready_i,
   input  logic                                  ret_v_i,
   input  logic [id_width_lp-1:0]                ret_id_i,
   input  logic                                  drain_i,
   output logic                                  idle_o,
   output logic [num_req_p*cnt_width_lp-1:0]     out_cnt_o,
   output logic                                  err_o
);

   localparam logic [id_width_lp:0]    num_req_lp = (id_width_lp + 1)'(num_req_p);
   localparam logic [cnt_width_lp-1:0] max_out_lp = cnt_width_lp'(max_out_p);
   localparam logic [id_width_lp-1:0]  last_id_lp = id_width_lp'(num_req_p - 1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE_DONE} state_e;

   state_e                  r_state;
   logic [cnt_width_lp-1:0] r_cnt [num_req_p];
   logic                    r_out_v;
   logic [packet_width_p-1:0] r_out_data;
   logic [id_width_lp-1:0]  r_rr_ptr;
   logic                    r_err;

   logic                    w_load_en;
   logic                    w_ret_ok;
   logic                    w_all_zero;
   logic                    w_found;
   logic                    w_accept;
   logic                    w_err_set;
   logic [num_req_p-1:0]    w_elig;
   logic [num_req_p-1:0]    w_cnt_zero;
   logic [num_req_p-1:0]    w_dec;
   logic [id_width_lp-1:0]  w_winner;
   logic [id_width_lp-1:0]  w_rr_next;
   logic [packet_width_p-1:0] w_sel_data;
   int unsigned             v_idx;

   assign w_load_en = ~r_out_v | (r_out_v & link_ready_i);
   assign w_ret_ok  = {1'b0, ret_id_i} < num_req_lp;

   // Eligibility gates on credits and on the quiesce mode (drain request blocks at once).
   always_comb begin
      w_elig     = '0;
      w_cnt_zero = '0;
      w_dec      = '0;
      w_all_zero = 1'b1;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         w_elig[i]     = req_v_i[i] & (r_cnt[i] < max_out_lp) & (r_state == S_RUN) & ~drain_i;
         w_cnt_zero[i] = (r_cnt[i] == '0);
         w_dec[i]      = ret_v_i & w_ret_ok & (ret_id_i == id_width_lp'(i));
         w_all_zero    = w_all_zero & w_cnt_zero[i];
      end
   end

   // First eligible requester at or after the round-robin pointer.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         v_idx = (32'(r_rr_ptr) + k) % num_req_p;
         if (!w_found && w_elig[id_width_lp'(v_idx)]) begin
            w_found  = 1'b1;
            w_winner = id_width_lp'(v_idx);
         end
      end
   end

   assign w_accept  = w_found & w_load_en & ~reset_i;
   assign w_rr_next = (w_winner == last_id_lp) ? '0 : w_winner + id_width_lp'(1);

   always_comb begin
      req_ready_o = '0;
      w_sel_data  = '0;
      for (int unsigned i = 0; i < num_req_p; i++) begin
         req_ready_o[i] = w_accept & (w_winner == id_width_lp'(i));
         if (w_winner == id_width_lp'(i))
            w_sel_data = req_data_i[i*packet_width_p +: packet_width_p];
      end
   end

   // A return without a matching outstanding request (or to a bogus id) is a protocol error.
   assign w_err_set = (ret_v_i & ~w_ret_ok) | (|(w_dec & ~req_ready_o & w_cnt_zero));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= S_RUN;
         r_out_v    <= 1'b0;
         r_out_data <= '0;
         r_rr_ptr   <= '0;
         r_err      <= 1'b0;
         for (int unsigned i = 0; i < num_req_p; i++) r_cnt[i] <= '0;
      end else begin
         if (w_load_en) begin
            r_out_v <= w_accept;
            if (w_accept) r_out_data <= w_sel_data;
         end
         if (w_accept) r_rr_ptr <= w_rr_next;
         if (w_err_set) r_err <= 1'b1;
         for (int unsigned i = 0; i < num_req_p; i++) begin
            if (req_ready_o[i] & ~w_dec[i])
               r_cnt[i] <= r_cnt[i] + cnt_width_lp'(1);
            else if (w_dec[i] & ~req_ready_o[i] & ~w_cnt_zero[i])
               r_cnt[i] <= r_cnt[i] - cnt_width_lp'(1);
         end
         case (r_state)
            S_RUN:       if (drain_i) r_state <= S_DRAIN;
            S_DRAIN:     if (!drain_i) r_state <= S_RUN;
                         else if (~r_out_v & w_all_zero) r_state <= S_IDLE_DONE;
            S_IDLE_DONE: if (!drain_i) r_state <= S_RUN;
            default:     r_state <= S_RUN;
         endcase
      end
   end

   always_comb begin
      out_cnt_o = '0;
      for (int unsigned i = 0; i < num_req_p; i++)
         out_cnt_o[i*cnt_width_lp +: cnt_width_lp] = r_cnt[i];
   end

   assign link_v_o    = r_out_v;
   assign link_data_o = r_out_data;
   assign idle_o      = ~r_out_v & w_all_zero;
   assign err_o       = r_err;

endmodule

// File: tb/tb_bsg_manycore_edge_inject_arb.sv
// Directed bench for the edge injection arbiter: a queue/counter model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_bsg_manycore_edge_inject_arb;

   localparam int N   = 3;
   localparam int W   = 16;
   localparam int MAX = 2;
   localparam int CW  = 2;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_v;
   logic [N*W-1:0]    req_data;
   logic [N-1:0]      req_ready;
   logic              link_v;
   logic [W-1:0]      link_data;
   logic              link_ready;
   logic              ret_v;
   logic [IW-1:0]     ret_id;
   logic              drain;
   logic              idle;
   logic [N*CW-1:0]   out_cnt;
   logic              err;

   always #5 clk = ~clk;

   bsg_manycore_edge_inject_arb #(
      .num_req_p(N), .packet_width_p(W), .max_out_p(MAX)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
      .link_v_o(link_v), .link_data_o(link_data), .link_ready_i(link_ready),
      .ret_v_i(ret_v), .ret_id_i(ret_id), .drain_i(drain),
      .idle_o(idle), .out_cnt_o(out_cnt), .err_o(err)
   );

   int checks   = 0;
   int failures = 0;

   // Model: packets in flight on the link, outstanding counts, priority pointer, mode.
   logic [W-1:0] mq[$];
   logic [W-1:0] mdata = '0;
   int           mcnt[N];
   int           mrr   = 0;
   bit           merr  = 1'b0;
   int           mmode = 0; // 0 running, 1 draining, 2 quiesced

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare DUT outputs to the model, then advance the model across the edge.
   task automatic step();
      int win;
      int rid;
      bit space;
      bit midle;
      logic [N-1:0]    er;
      logic [N*CW-1:0] ec;
      #1;
      win   = -1;
      space = (mq.size() == 0) || link_ready;
      if (!reset && space && mmode == 0 && !drain)
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mrr + k) % N;
            if (win < 0 && req_v[i] && mcnt[i] < MAX) win = i;
         end
      er = '0;
      if (win >= 0) er[win] = 1'b1;
      ec    = '0;
      midle = (mq.size() == 0);
      for (int i = 0; i < N; i++) begin
         ec[i*CW +: CW] = CW'(mcnt[i]);
         if (mcnt[i] != 0) midle = 1'b0;
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("link_v",    64'(link_v),    64'(mq.size() != 0));
      chk("link_data", 64'(link_data), 64'(mdata));
      chk("out_cnt",   64'(out_cnt),   64'(ec));
      chk("idle",      64'(idle),      64'(midle));
      chk("err",       64'(err),       64'(merr));
      @(posedge clk);
      #1;
      if (reset) begin
         mq.delete();
         mdata = '0;
         for (int i = 0; i < N; i++) mcnt[i] = 0;
         mrr = 0; merr = 1'b0; mmode = 0;
      end else begin
         if (mq.size() != 0 && link_ready) void'(mq.pop_front());
         if (win >= 0) begin
            mdata = req_data[win*W +: W];
            mq.push_back(mdata);
            mrr = (win + 1) % N;
         end
         rid = int'(ret_id);
         if (ret_v) begin
            if (rid >= N) merr = 1'b1;
            else if (rid != win) begin
               if (mcnt[rid] == 0) merr = 1'b1;
               else mcnt[rid]--;
            end
         end
         if (win >= 0 && !(ret_v && rid == win)) mcnt[win]++;
         case (mmode)
            0: if (drain) mmode = 1;
            1: if (!drain) mmode = 0; else if (midle) mmode = 2;
            default: if (!drain) mmode = 0;
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      reset = 1'b1; req_v = '0; req_data = '0; link_ready = 1'b1;
      ret_v = 1'b0; ret_id = '0; drain = 1'b0;
      @(posedge clk);
      #1;
      step();
      reset = 1'b0;
      chk("rst_link_v", 64'(link_v), 64'd0);
      chk("rst_idle",   64'(idle),   64'd1);
      chk("rst_cnt",    64'(out_cnt), 64'd0);

      // 1: all requesting, returns trail grants by a cycle -> strict rotation
      req_v = 3'b111;
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'(16'h1000 * i + c);
         ret_v  = (c > 0);
         ret_id = (c > 0) ? IW'((c - 1) % N) : '0;
         #1;
         chk("t1_grant", 64'(req_ready), 64'd1 << (c % N));
         step();
         chk("t1_link_v", 64'(link_v), 64'd1);
         chk("t1_data", 64'(link_data), 64'(16'h1000 * (c % N) + c));
      end
      req_v = '0; ret_v = 1'b1; ret_id = 2'd2;
      step();
      ret_v = 1'b0;
      chk("t1_idle", 64'(idle), 64'd1);

      // 2: single requester runs out of credits, one return re-opens it
      req_v = 3'b010;
      for (int j = 0; j < 2; j++) begin
         req_data[W +: W] = 16'(16'hB100 + j);
         step();
      end
      #1;
      chk("t2_blocked", 64'(req_ready), 64'd0);
      chk("t2_cnt1", 64'(out_cnt[3:2]), 64'd2);
      step();
      ret_v = 1'b1; ret_id = 2'd1;
      #1;
      chk("t2_ret_cycle", 64'(req_ready), 64'd0);
      step();
      ret_v = 1'b0;
      #1;
      chk("t2_regrant", 64'(req_ready), 64'b010);
      step();
      req_v = '0; ret_v = 1'b1; ret_id = 2'd1;
      step();
      step();
      ret_v = 1'b0;
      step();
      chk("t2_cnt_clear", 64'(out_cnt), 64'd0);

      // 3: link back-pressure holds packet A; release retires A and loads B together
      link_ready = 1'b0; req_v = 3'b001; req_data[0 +: W] = 16'hAAAA;
      #1;
      chk("t3_accept_a", 64'(req_ready), 64'b001);
      step();
      req_v = 3'b111; req_data = {16'hC2C2, 16'hBBBB, 16'hC0C0};
      for (int j = 0; j < 5; j++) begin
         #1;
         chk("t3_stall_ready", 64'(req_ready), 64'd0);
         chk("t3_stall_data", 64'(link_data), 64'hAAAA);
         step();
      end
      link_ready = 1'b1;
      #1;
      chk("t3_accept_b", 64'(req_ready), 64'b010);
      step();
      chk("t3_data_b", 64'(link_data), 64'hBBBB);
      req_v = '0; ret_v = 1'b1; ret_id = 2'd0;
      step();
      ret_id = 2'd1;
      step();
      ret_v = 1'b0;
      step();

      // 4: same-cycle inc/dec cancels; stray and out-of-range returns set the sticky error
      req_v = 3'b100; req_data[2*W +: W] = 16'h4444;
      step();
      ret_v = 1'b1; ret_id = 2'd2; req_data[2*W +: W] = 16'h4445;
      #1;
      chk("t4_grant2", 64'(req_ready), 64'b100);
      step();
      chk("t4_cnt2", 64'(out_cnt[5:4]), 64'd1);
      req_v = '0; ret_id = 2'd0;
      step();
      chk("t4_err", 64'(err), 64'd1);
      chk("t4_cnt0", 64'(out_cnt[1:0]), 64'd0);
      ret_v = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t4_err_rst", 64'(err), 64'd0);
      ret_v = 1'b1; ret_id = 2'd3;
      step();
      ret_v = 1'b0;
      chk("t4_err_id", 64'(err), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;

      // 5: drain with cnt={1,0,2} and one packet staged, then resume
      link_ready = 1'b1; req_v = 3'b101;
      req_data = {16'h5200, 16'h0000, 16'h5000};
      step();
      req_v = 3'b100; req_data[2*W +: W] = 16'h5201;
      step();
      req_data[2*W +: W] = 16'h5202;
      step();
      drain = 1'b1; link_ready = 1'b0; req_v = 3'b111;
      #1;
      chk("t5_no_grant", 64'(req_ready), 64'd0);
      step();
      chk("t5_busy", 64'(idle), 64'd0);
      link_ready = 1'b1;
      step();
      chk("t5_drained", 64'(link_v), 64'd0);
      ret_v = 1'b1; ret_id = 2'd0;
      step();
      ret_id = 2'd2;
      step();
      chk("t5_still_busy", 64'(idle), 64'd0);
      step();
      ret_v = 1'b0;
      chk("t5_idle", 64'(idle), 64'd1);
      step();
      #1;
      chk("t5_quiesced", 64'(req_ready), 64'd0);
      step();
      drain = 1'b0;
      #1;
      chk("t5_leave", 64'(req_ready), 64'd0);
      step();
      #1;
      chk("t5_resume", 64'(req_ready), 64'b001);
      step();
      req_v = '0; ret_v = 1'b1; ret_id = 2'd0;
      step();
      ret_v = 1'b0;
      step();

      // 6: reset while a packet is stalled on the link
      req_v = 3'b010; link_ready = 1'b0; ret_v = 1'b1; ret_id = 2'd3;
      req_data[W +: W] = 16'h6666;
      step();
      ret_v = 1'b0;
      chk("t6_held", 64'(link_v), 64'd1);
      chk("t6_err_pre", 64'(err), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_link_v", 64'(link_v), 64'd0);
      chk("t6_data", 64'(link_data), 64'd0);
      chk("t6_cnt", 64'(out_cnt), 64'd0);
      chk("t6_err", 64'(err), 64'd0);
      req_v = 3'b111; link_ready = 1'b1;
      #1;
      chk("t6_first", 64'(req_ready), 64'b001);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
